// File: rtl/memory_dp_param_pkg.sv
// Shared types for the parametrised dual-port memory: request struct typedef macros
// (so each instance can size them from its own parameters) and the clear FSM state.
`ifndef MEMORY_DP_PARAM_PKG_SV
`define MEMORY_DP_PARAM_PKG_SV

`define MEMORY_DP_WR_REQ_T(name, aw, w) typedef struct packed { logic wr_vld; logic [(aw)-1:0] wr_address; logic [(w)/8-1:0] wr_mask; } name;
`define MEMORY_DP_RD_REQ_T(name, aw) typedef struct packed { logic rd_vld; logic [(aw)-1:0] rd_address; } name;

package memory_dp_param_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

  localparam int BYTE_W = 8;

  function automatic int num_bytes(input int width);
    return width / BYTE_W;
  endfunction

endpackage

`endif

// File: rtl/memory_dp_param_if.sv
// Write/read bus of the dual-port memory; master drives requests, slave returns read data.
interface memory_dp_param_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic                 m_wr_vld;
  logic [ADDR_W-1:0]    m_wr_address;
  logic [WIDTH-1:0]     m_wr_data;
  logic [WIDTH/8-1:0]   m_wr_mask;
  logic                 m_rd_vld;
  logic [ADDR_W-1:0]    m_rd_address;
  logic [WIDTH-1:0]     m_rd_data;
  logic                 m_rd_data_vld;
  logic                 init_done;

  modport master (
    output m_wr_vld, m_wr_address, m_wr_data, m_wr_mask, m_rd_vld, m_rd_address,
    input  m_rd_data, m_rd_data_vld, init_done
  );

  modport slave (
    input  m_wr_vld, m_wr_address, m_wr_data, m_wr_mask, m_rd_vld, m_rd_address,
    output m_rd_data, m_rd_data_vld, init_done
  );
endinterface

// File: rtl/memory_dp_clear.sv
// Post-reset clear sequencer: walks every entry once writing zero, then reports ready.
//   state    | meaning
//   ST_CLEAR | zeroing entry clear_cnt_q, user traffic ignored
//   ST_READY | memory accepts reads and writes
module memory_dp_clear
  import memory_dp_param_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam mem_state_e        RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clear_cnt_q, clear_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    clear_we    = 1'b0;
    clear_addr  = clear_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clear_we = 1'b1;
        if (clear_cnt_q == LAST_ADDR) begin
          state_d     = ST_READY;
          clear_cnt_d = '0;
        end else begin
          clear_cnt_d = clear_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign init_done = (state_q == ST_READY);

endmodule

// File: rtl/memory_dp_param.sv
// Parametrised simple dual-port memory: byte-masked write port, two-stage read port with
// write-first bypass, out-of-range protection and optional post-reset clear.
module memory_dp_param
  import memory_dp_param_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  memory_dp_param_if.slave bus
);

  localparam int                NB      = num_bytes(WIDTH);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  `MEMORY_DP_WR_REQ_T(wr_req_t, ADDR_W, WIDTH)
  `MEMORY_DP_RD_REQ_T(rd_req_t, ADDR_W)

  wr_req_t           wr_req;
  rd_req_t           rd_req;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;
  logic              init_done;

  logic              wr_in_range, wr_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [NB-1:0]     mem_be;
  logic [WIDTH-1:0]  mem_wdata;

  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_data_vld_q, rd_data_vld_d;
  logic              rd_in_range;
  logic [ADDR_W-1:0] rd_idx;
  logic [WIDTH-1:0]  rd_word;

  memory_dp_clear #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk        (clk),
    .reset      (reset),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .init_done  (init_done)
  );

  assign wr_req = '{wr_vld: bus.m_wr_vld, wr_address: bus.m_wr_address, wr_mask: bus.m_wr_mask};
  assign rd_req = '{rd_vld: bus.m_rd_vld, rd_address: bus.m_rd_address};

  // The clear sequencer owns the array port until init_done; user writes are dropped then.
  always_comb begin
    wr_in_range = ({1'b0, wr_req.wr_address} < DEPTH_X);
    wr_fire     = init_done && wr_req.wr_vld && wr_in_range;
    mem_we      = 1'b0;
    mem_waddr   = wr_req.wr_address;
    mem_be      = wr_req.wr_mask;
    mem_wdata   = bus.m_wr_data;
    if (clear_we) begin
      mem_we    = 1'b1;
      mem_waddr = clear_addr;
      mem_be    = '1;
      mem_wdata = '0;
    end else if (wr_fire && (|wr_req.wr_mask)) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem_q[mem_waddr][b*BYTE_W +: BYTE_W] <= mem_wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Stage 1 reads the array after this cycle's write landed; a write arriving now is bypassed.
  always_comb begin
    rd_vld_d    = init_done && rd_req.rd_vld;
    rd_addr_d   = rd_vld_d ? rd_req.rd_address : rd_addr_q;
    rd_in_range = ({1'b0, rd_addr_q} < DEPTH_X);
    rd_idx      = rd_in_range ? rd_addr_q : '0;
    rd_word     = mem_q[rd_idx];
    for (int b = 0; b < NB; b++) begin
      if (wr_fire && (wr_req.wr_address == rd_addr_q) && wr_req.wr_mask[b])
        rd_word[b*BYTE_W +: BYTE_W] = bus.m_wr_data[b*BYTE_W +: BYTE_W];
    end
    if (!rd_in_range) rd_word = '0;
    rd_data_vld_d = rd_vld_q;
    rd_data_d     = rd_vld_q ? rd_word : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q      <= 1'b0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
      rd_data_vld_q <= 1'b0;
    end else begin
      rd_vld_q      <= rd_vld_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
      rd_data_vld_q <= rd_data_vld_d;
    end
  end

  assign bus.m_rd_data     = rd_data_q;
  assign bus.m_rd_data_vld = rd_data_vld_q;
  assign bus.init_done     = init_done;

endmodule

// File: tb/tb_memory_dp_param.sv
// Bench for memory_dp_param: DEPTH=16 and DEPTH=12 instances with clear, one without clear,
// checked against an array model where a read returns the entry after the following cycle's write.
module tb_memory_dp_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  memory_dp_param_if #(.WIDTH(32), .DEPTH(16)) ifa ();
  memory_dp_param_if #(.WIDTH(32), .DEPTH(12)) ifb ();
  memory_dp_param_if #(.WIDTH(32), .DEPTH(12)) ifc ();

  memory_dp_param #(.WIDTH(32), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  memory_dp_param #(.WIDTH(32), .DEPTH(12), .CLEAR_ON_RESET(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  memory_dp_param #(.WIDTH(32), .DEPTH(12), .CLEAR_ON_RESET(1'b0)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  logic [31:0] ma [16];
  logic [31:0] mb [16];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc, vld_seen;
  logic [31:0] last_a;
  logic        pa, pb, ra, rb;
  logic [3:0]  paa, pba;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_b(input logic [3:0] addr);
    return (addr < 4'd12) ? mb[addr] : 32'h0;
  endfunction

  task automatic idle_all();
    ifa.m_wr_vld = 0; ifa.m_wr_address = '0; ifa.m_wr_data = '0; ifa.m_wr_mask = '0; ifa.m_rd_vld = 0; ifa.m_rd_address = '0;
    ifb.m_wr_vld = 0; ifb.m_wr_address = '0; ifb.m_wr_data = '0; ifb.m_wr_mask = '0; ifb.m_rd_vld = 0; ifb.m_rd_address = '0;
    ifc.m_wr_vld = 0; ifc.m_wr_address = '0; ifc.m_wr_data = '0; ifc.m_wr_mask = '0; ifc.m_rd_vld = 0; ifc.m_rd_address = '0;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; end
  endtask

  task automatic wr_a(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] mask);
    ifa.m_wr_vld = 1; ifa.m_wr_address = addr; ifa.m_wr_data = data; ifa.m_wr_mask = mask;
    step();
    ifa.m_wr_vld = 0;
    ma[addr] = merge(ma[addr], data, mask);
  endtask

  task automatic wr_b(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] mask);
    ifb.m_wr_vld = 1; ifb.m_wr_address = addr; ifb.m_wr_data = data; ifb.m_wr_mask = mask;
    step();
    ifb.m_wr_vld = 0;
    if (addr < 4'd12) mb[addr] = merge(mb[addr], data, mask);
  endtask

  task automatic rd_a(input logic [3:0] addr);
    ifa.m_rd_vld = 1; ifa.m_rd_address = addr;
    step();
    ifa.m_rd_vld = 0;
    chk("a_rd_vld_early", {31'b0, ifa.m_rd_data_vld}, 32'd0);
    step();
    chk("a_rd_vld", {31'b0, ifa.m_rd_data_vld}, 32'd1);
    chk("a_rd_data", ifa.m_rd_data, ma[addr]);
    last_a = ma[addr];
  endtask

  task automatic rd_b(input logic [3:0] addr);
    ifb.m_rd_vld = 1; ifb.m_rd_address = addr;
    step();
    ifb.m_rd_vld = 0;
    step();
    chk("b_rd_vld", {31'b0, ifb.m_rd_data_vld}, 32'd1);
    chk("b_rd_data", ifb.m_rd_data, exp_b(addr));
  endtask

  initial begin
    idle_all();
    clear_models();
    reset = 1;
    repeat (3) step();
    chk("rst_a_vld", {31'b0, ifa.m_rd_data_vld}, 32'd0);
    chk("rst_a_data", ifa.m_rd_data, 32'd0);
    chk("rst_a_init", {31'b0, ifa.init_done}, 32'd0);
    chk("rst_b_init", {31'b0, ifb.init_done}, 32'd0);
    chk("rst_c_init", {31'b0, ifc.init_done}, 32'd1);
    chk("rst_c_data", ifc.m_rd_data, 32'd0);

    // traffic during clear must be ignored
    ifa.m_wr_vld = 1; ifa.m_wr_address = 4'd2; ifa.m_wr_data = 32'hFFFF_FFFF; ifa.m_wr_mask = 4'hF;
    ifa.m_rd_vld = 1; ifa.m_rd_address = 4'd2;
    ifb.m_wr_vld = 1; ifb.m_wr_address = 4'd2; ifb.m_wr_data = 32'hFFFF_FFFF; ifb.m_wr_mask = 4'hF;
    ifb.m_rd_vld = 1; ifb.m_rd_address = 4'd2;
    reset = 0;
    cyc = 0; vld_seen = 0;
    while (!ifa.init_done && cyc < 64) begin
      step();
      cyc++;
      if (ifa.m_rd_data_vld || ifb.m_rd_data_vld) vld_seen++;
      if (cyc == 11) begin
        chk("b_init_before_12", {31'b0, ifb.init_done}, 32'd0);
        ifb.m_wr_vld = 0; ifb.m_rd_vld = 0;
      end
      if (cyc == 12) chk("b_init_at_12", {31'b0, ifb.init_done}, 32'd1);
      if (cyc == 15) begin ifa.m_wr_vld = 0; ifa.m_rd_vld = 0; end
    end
    chk("a_clear_len", cyc, 32'd16);
    step();
    if (ifa.m_rd_data_vld || ifb.m_rd_data_vld) vld_seen++;
    chk("clear_no_resp", vld_seen, 32'd0);

    // instance without clear is usable immediately
    ifc.m_wr_vld = 1; ifc.m_wr_address = 4'd4; ifc.m_wr_data = 32'h1234_5678; ifc.m_wr_mask = 4'hF;
    step();
    ifc.m_wr_vld = 0; ifc.m_rd_vld = 1; ifc.m_rd_address = 4'd4;
    step();
    ifc.m_rd_vld = 0;
    step();
    chk("c_rd_vld", {31'b0, ifc.m_rd_data_vld}, 32'd1);
    chk("c_rd_data", ifc.m_rd_data, 32'h1234_5678);

    for (int i = 0; i < 16; i++) rd_a(4'(i));

    wr_a(4'd3, 32'hDEAD_BEEF, 4'hF);
    wr_a(4'd3, 32'h1122_3344, 4'h5);
    rd_a(4'd3);
    chk("a_mask_const", ifa.m_rd_data, 32'hDE22_BE44);

    // write one cycle after the read request is bypassed into the result
    ifa.m_rd_vld = 1; ifa.m_rd_address = 4'd5;
    step();
    ifa.m_rd_vld = 0;
    ifa.m_wr_vld = 1; ifa.m_wr_address = 4'd5; ifa.m_wr_data = 32'hA5A5_A5A5; ifa.m_wr_mask = 4'hF;
    step();
    ifa.m_wr_vld = 0;
    ma[5] = merge(ma[5], 32'hA5A5_A5A5, 4'hF);
    chk("byp_full_vld", {31'b0, ifa.m_rd_data_vld}, 32'd1);
    chk("byp_full_data", ifa.m_rd_data, ma[5]);
    ifa.m_rd_vld = 1; ifa.m_rd_address = 4'd6;
    step();
    ifa.m_rd_vld = 0;
    ifa.m_wr_vld = 1; ifa.m_wr_address = 4'd6; ifa.m_wr_data = 32'hA5A5_A5A5; ifa.m_wr_mask = 4'h1;
    step();
    ifa.m_wr_vld = 0;
    ma[6] = merge(ma[6], 32'hA5A5_A5A5, 4'h1);
    chk("byp_byte_data", ifa.m_rd_data, 32'h0000_00A5);
    last_a = ma[6];

    // DEPTH=12: out-of-range write dropped, out-of-range read answers zero
    for (int i = 0; i < 12; i++) wr_b(4'(i), $urandom, 4'hF);
    wr_b(4'd13, 32'hFFFF_FFFF, 4'hF);
    rd_b(4'd13);
    for (int i = 0; i < 12; i++) rd_b(4'(i));

    // random concurrent traffic on both instances
    pa = 0; pb = 0; paa = '0; pba = '0;
    for (int i = 0; i < 200; i++) begin
      ifa.m_wr_vld = 1'($urandom_range(0, 1)); ifa.m_wr_address = 4'($urandom_range(0, 15)) & ($urandom_range(0, 1) ? 4'h3 : 4'hF);
      ifa.m_wr_data = $urandom; ifa.m_wr_mask = 4'($urandom_range(0, 15));
      ifa.m_rd_vld = 1'($urandom_range(0, 1)); ifa.m_rd_address = 4'($urandom_range(0, 15)) & ($urandom_range(0, 1) ? 4'h3 : 4'hF);
      ifb.m_wr_vld = 1'($urandom_range(0, 1)); ifb.m_wr_address = 4'($urandom_range(0, 15));
      ifb.m_wr_data = $urandom; ifb.m_wr_mask = 4'($urandom_range(0, 15));
      ifb.m_rd_vld = 1'($urandom_range(0, 1)); ifb.m_rd_address = 4'($urandom_range(0, 15));
      ra = ifa.m_rd_vld; rb = ifb.m_rd_vld;
      step();
      if (ifa.m_wr_vld) ma[ifa.m_wr_address] = merge(ma[ifa.m_wr_address], ifa.m_wr_data, ifa.m_wr_mask);
      if (ifb.m_wr_vld && ifb.m_wr_address < 4'd12) mb[ifb.m_wr_address] = merge(mb[ifb.m_wr_address], ifb.m_wr_data, ifb.m_wr_mask);
      chk("rnd_a_vld", {31'b0, ifa.m_rd_data_vld}, {31'b0, pa});
      if (pa) last_a = ma[paa];
      chk("rnd_a_data", ifa.m_rd_data, last_a);
      chk("rnd_b_vld", {31'b0, ifb.m_rd_data_vld}, {31'b0, pb});
      if (pb) chk("rnd_b_data", ifb.m_rd_data, exp_b(pba));
      pa = ra; paa = ifa.m_rd_address;
      pb = rb; pba = ifb.m_rd_address;
    end
    idle_all();
    step();
    chk("rnd_a_tail_vld", {31'b0, ifa.m_rd_data_vld}, {31'b0, pa});
    if (pa) last_a = ma[paa];
    chk("rnd_a_tail_data", ifa.m_rd_data, last_a);

    // back-to-back stream, one result per cycle in order
    for (int i = 0; i < 16; i++) begin
      ifa.m_rd_vld = 1; ifa.m_rd_address = 4'(i);
      step();
      if (i > 0) begin
        chk("stream_vld", {31'b0, ifa.m_rd_data_vld}, 32'd1);
        chk("stream_data", ifa.m_rd_data, ma[i-1]);
      end
    end
    ifa.m_rd_vld = 0;
    step();
    chk("stream_last_vld", {31'b0, ifa.m_rd_data_vld}, 32'd1);
    chk("stream_last_data", ifa.m_rd_data, ma[15]);

    // reset with a read outstanding drops it and restarts the clear
    ifa.m_rd_vld = 1; ifa.m_rd_address = 4'd7;
    step();
    ifa.m_rd_address = 4'd8;
    step();
    chk("pre_rst_data", ifa.m_rd_data, ma[7]);
    reset = 1;
    step();
    chk("mid_rst_vld", {31'b0, ifa.m_rd_data_vld}, 32'd0);
    chk("mid_rst_data", ifa.m_rd_data, 32'd0);
    chk("mid_rst_init", {31'b0, ifa.init_done}, 32'd0);
    ifa.m_rd_vld = 0;
    reset = 0;
    clear_models();
    cyc = 0;
    while (!ifa.init_done && cyc < 64) begin
      step();
      cyc++;
    end
    chk("reclear_len", cyc, 32'd16);
    rd_a(4'd2);
    rd_a(4'd3);
    rd_b(4'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
